// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the single write port of the synchronous FIFO.
// Locks onto one producer for up to BURST words, then rotates priority.
module fifo_wr_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  parameter  int BURST = 4,
  localparam int ID_W  = $clog2(NREQ),
  localparam int CNT_W = $clog2(BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_wr_data,
  input  logic                  fifo_full,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]        rr_pick, sel;
  logic                   any_vld, xfer, last_beat;
  logic [NREQ-1:0][WIDTH-1:0] words;
  int                     idx;

  assign words = req_data;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(NREQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // Scan from the farthest offset down so the nearest valid index after rr_ptr wins.
  always_comb begin
    rr_pick = rr_ptr_q;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) rr_pick = ID_W'(idx);
    end
  end

  assign any_vld   = |req_valid;
  assign sel       = (state_q == LOCKED) ? owner_q : rr_pick;
  assign xfer      = req_valid[sel] && !fifo_full && ((state_q == LOCKED) || any_vld);
  assign last_beat = (beat_cnt_q + CNT_W'(1)) == CNT_W'(BURST);

  assign fifo_wr_en   = xfer;
  assign req_ready    = xfer ? (NREQ'(1) << sel) : '0;
  assign fifo_wr_data = xfer ? words[sel] : '0;
  assign grant_id     = sel;
  assign busy         = (state_q == LOCKED);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (BURST == 1) begin
            rr_ptr_d = wrap_inc(sel);
          end else begin
            state_d    = LOCKED;
            owner_d    = sel;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          if (last_beat) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_inc(owner_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else if (!req_valid[owner_q]) begin
          // Owner went away mid-burst: give up the lock, nothing written this cycle.
          state_d    = IDLE;
          rr_ptr_d   = wrap_inc(owner_q);
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int ID_W  = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ*WIDTH-1:0]      req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       fifo_wr_en;
  logic [WIDTH-1:0]           fifo_wr_data;
  logic                       fifo_full = 1'b0;
  logic [ID_W-1:0]            grant_id;
  logic                       busy;

  logic [NREQ-1:0]            vld = '0;
  logic [NREQ-1:0][WIDTH-1:0] dat = '0;
  logic [NREQ-1:0]            acc;

  int checks = 0;
  int errors = 0;

  assign req_valid = vld;
  assign req_data  = dat;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask

  // Behavioural model: who owns the port, how many words taken, where priority starts.
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_rr     = 0;
  int m_beats  = 0;

  function automatic int pick();
    if (m_locked) return m_owner;
    for (int k = 0; k < NREQ; k++)
      if (vld[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return m_rr;
  endfunction

  initial begin : compare
    int  s;
    bit  xf;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_locked = 1'b0; m_owner = 0; m_rr = 0; m_beats = 0;
      end
      s  = pick();
      xf = vld[s] && !fifo_full;
      chk("m_wr_en", fifo_wr_en, xf);
      chk("m_ready", req_ready, xf ? (32'd1 << s) : 32'd0);
      chk("m_data",  fifo_wr_data, xf ? dat[s] : 8'd0);
      chk("m_grant", grant_id, s);
      chk("m_busy",  busy, m_locked);
      if (!rst) begin
        if (m_locked) begin
          if (xf) begin
            m_beats++;
            if (m_beats == BURST) begin
              m_locked = 1'b0; m_rr = (m_owner + 1) % NREQ; m_beats = 0;
            end
          end else if (!vld[m_owner]) begin
            m_locked = 1'b0; m_rr = (m_owner + 1) % NREQ; m_beats = 0;
          end
        end else if (xf) begin
          m_locked = 1'b1; m_owner = s; m_beats = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rst_dut();
    rst = 1'b1; vld = '0; fifo_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic present(input int i, input logic [WIDTH-1:0] w);
    vld[i] = 1'b1;
    dat[i] = w;
  endtask

  initial begin : drive
    int e;
    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_grant", grant_id, 0);
    tick(); tick();
    rst = 1'b0;

    // single requester 2, ten words
    rst_dut();
    present(2, 8'h10);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("single_en", fifo_wr_en, 1);
      chk("single_gid", grant_id, 2);
      chk("single_data", fifo_wr_data, 8'h10 + n);
      chk("single_busy", busy, (n % 4) != 0);
      tick();
      if (n < 9) present(2, 8'(8'h11 + n)); else vld[2] = 1'b0;
    end

    // all four continuously valid
    rst_dut();
    for (int i = 0; i < NREQ; i++) present(i, 8'(i * 16));
    for (int n = 0; n < 17; n++) begin
      e = (n / 4) % 4;
      @(negedge clk);
      chk("rr_gid", grant_id, e);
      chk("rr_en", fifo_wr_en, 1);
      chk("rr_busy", busy, (n % 4) != 0);
      tick();
      present(e, 8'(dat[e] + 1));
    end

    // backpressure on owner 1 at beat 2
    rst_dut();
    present(1, 8'h40);
    @(negedge clk); chk("bp_gid0", grant_id, 1); chk("bp_en0", fifo_wr_en, 1);
    tick(); present(1, 8'h41);
    @(negedge clk); chk("bp_data1", fifo_wr_data, 8'h41);
    tick(); present(1, 8'h42); fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stall_en", fifo_wr_en, 0);
      chk("bp_stall_rdy", req_ready, 0);
      chk("bp_stall_busy", busy, 1);
      tick();
      if (k == 0) present(3, 8'h70);
      if (k == 4) fifo_full = 1'b0;
    end
    @(negedge clk); chk("bp_data2", fifo_wr_data, 8'h42); chk("bp_gid2", grant_id, 1);
    tick(); present(1, 8'h43);
    @(negedge clk); chk("bp_data3", fifo_wr_data, 8'h43); chk("bp_busy3", busy, 1);
    tick(); present(1, 8'h44);
    @(negedge clk); chk("bp_next_gid", grant_id, 3); chk("bp_next_data", fifo_wr_data, 8'h70);

    // early release by 0, then 3, then wrap back to 0
    rst_dut();
    present(0, 8'hA0); present(3, 8'hD0);
    @(negedge clk); chk("er_gid0", grant_id, 0); chk("er_data0", fifo_wr_data, 8'hA0);
    tick(); present(0, 8'hA1);
    @(negedge clk); chk("er_data1", fifo_wr_data, 8'hA1); chk("er_busy1", busy, 1);
    tick(); vld[0] = 1'b0;
    @(negedge clk); chk("er_idle_en", fifo_wr_en, 0); chk("er_idle_busy", busy, 1);
    tick();
    @(negedge clk); chk("er_gid3", grant_id, 3); chk("er_data3", fifo_wr_data, 8'hD0);
    for (int k = 1; k < 4; k++) begin
      tick(); present(3, 8'(8'hD0 + k));
      @(negedge clk); chk("wrap_gid3", grant_id, 3); chk("wrap_data3", fifo_wr_data, 8'hD0 + k);
    end
    tick(); present(3, 8'hD4); present(0, 8'hA2);
    @(negedge clk); chk("wrap_gid0", grant_id, 0); chk("wrap_data0", fifo_wr_data, 8'hA2);

    // reset mid-burst: owner 2 at beat 2
    rst_dut();
    present(2, 8'hB0);
    @(negedge clk); chk("mr_en0", fifo_wr_en, 1);
    tick(); present(2, 8'hB1);
    @(negedge clk); chk("mr_busy1", busy, 1);
    tick();
    rst = 1'b1; vld = '0;
    #1;
    chk("mr_busy_now", busy, 0);
    chk("mr_en_now", fifo_wr_en, 0);
    tick(); tick();
    rst = 1'b0; present(1, 8'hC1); present(2, 8'hB2);
    @(negedge clk); chk("mr_gid1", grant_id, 1); chk("mr_data1", fifo_wr_data, 8'hC1);
    tick();

    // randomized traffic, valid held until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      if ($urandom_range(0, 599) == 0) begin
        rst_dut();
        continue;
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (vld[i] && acc[i]) begin
          if ($urandom_range(0, 3) == 0) vld[i] = 1'b0;
          else present(i, 8'($urandom));
        end else if (!vld[i] && $urandom_range(0, 2) == 0) begin
          present(i, 8'($urandom));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the team's synchronous FIFO among `NREQ` producers. Each producer presents a valid/ready stream. The arbiter locks onto one producer for bursts of up to `BURST` words, then rotates priority. It drives the FIFO's `wr_en`/`wr_data` directly and honours its `full` flag, so no word is lost or duplicated.

## Interface

Parameters:
- `WIDTH`, 8: data word width; matches the FIFO `WIDTH`.
- `NREQ`, 4: number of requesters; must be 2 or more.
- `BURST`, 4: maximum consecutive transfers granted to one owner; must be 1 or more.
- `ID_W` (localparam) = `$clog2(NREQ)`.
- `CNT_W` (localparam) = `$clog2(BURST+1)`.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  `NREQ`  per-requester data valid.
- `req_data`  in  `NREQ*WIDTH`  requester i's word at bits [i*WIDTH +: WIDTH].
- `req_ready`  out  `NREQ`  one-hot or zero; word i is accepted this cycle.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_wr_data`  out  `WIDTH`  FIFO write data.
- `fifo_full`  in  1  FIFO full flag.
- `grant_id`  out  `ID_W`  current or selected owner index.
- `busy`  out  1  high while in state LOCKED.

## Operation

- Registered state:
  - `state` ∈ {IDLE, LOCKED}
  - `owner` (`ID_W` bits)
  - `rr_ptr` (`ID_W` bits): highest-priority index in IDLE
  - `beat_cnt` (`CNT_W` bits)
- Selection `sel`:
  - In IDLE: the first i with `req_valid[i]`, searching `rr_ptr`, `rr_ptr+1`, … modulo `NREQ`. Default is `rr_ptr` if no requester is valid.
  - In LOCKED: `owner`.
- Transfer `xfer` = `req_valid[sel] && !fifo_full`. In IDLE, `xfer` additionally requires at least one valid.
- Outputs are combinational from state and inputs:
  - `fifo_wr_en` = `xfer`.
  - `req_ready` = one-hot at `sel` when `xfer`, else 0.
  - `fifo_wr_data` = `req_data[sel]` when `xfer`, else 0.
  - `grant_id` = `sel`.
  - `busy` = (state == LOCKED).
- IDLE, when `xfer`:
  - If `BURST == 1`: stay in IDLE; `rr_ptr <= sel+1` mod `NREQ`.
  - Otherwise: go to LOCKED; `owner <= sel`; `beat_cnt <= 1`.
- IDLE, any valid but `fifo_full`: stay in IDLE. No lock is taken and no state changes.
- LOCKED:
  - `xfer` and `beat_cnt+1 == BURST`: return to IDLE; `rr_ptr <= owner+1` mod `NREQ`; `beat_cnt <= 0`.
  - `xfer` otherwise: `beat_cnt <= beat_cnt+1`.
  - `!req_valid[owner]`: return to IDLE; `rr_ptr <= owner+1` mod `NREQ`; `beat_cnt <= 0`. This is an early release and nothing is written.
  - `req_valid[owner] && fifo_full`: stall. Remain LOCKED with `beat_cnt` unchanged.
- Other requesters' `req_valid` is ignored while LOCKED.
- Modulo wrap: `owner+1` with `owner == NREQ-1` wraps to 0, including for non-power-of-two `NREQ`.
- Requesters must not make `req_valid` depend on `req_ready`. `req_data[i]` must stay stable while `req_valid[i]` is high and not yet accepted.

## Timing

- Reset (asynchronous, immediate on `rst` rising):
  - `state` = IDLE; `owner`, `rr_ptr`, `beat_cnt` = 0.
  - Outputs follow combinationally: `busy`=0, `grant_id`=0 when no valid, and `fifo_wr_en`/`req_ready`/`fifo_wr_data` = 0 unless an input is valid while `fifo_full`=0.
  - The first arbitration is on the first rising edge after `rst` deasserts. A burst in progress at reset is abandoned; words already written remain written.
- Latency: zero cycles. A word accepted at edge N (`req_ready` and `fifo_wr_en` high) is captured by the FIFO at edge N.
- Throughput: one word per cycle while not full.
  - No bubble between bursts: the cycle after a BURST-end release arbitrates in IDLE and transfers in that same cycle.
  - An early release (valid dropped) costs that one cycle only.
- `fifo_full` is combinational into `fifo_wr_en`. A write is never issued while `fifo_full`=1.

## Test plan

- Single requester: `NREQ`=4, `BURST`=4, only req 2 valid, 10 words 0x10..0x19, FIFO never full -> 10 consecutive `fifo_wr_en` cycles, data in order. `busy` drops for one cycle after every 4th beat; `grant_id`=2 throughout.
- All four requesters continuously valid, `BURST`=4 -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…. 16 writes in 16 cycles; no interleaving within a burst.
- Backpressure: owner 1 locked with `beat_cnt`=2, `fifo_full`=1 for 5 cycles -> `fifo_wr_en`=0, `req_ready`=0, `busy`=1, `beat_cnt` held. After full drops, exactly 2 more words from req 1, then rotation to the next valid requester.
- Early release: req 0 valid for 2 words then deasserts; req 3 valid -> after 2 writes from 0, one idle cycle, then req 3 granted (priority from `rr_ptr`=1 finds 3).
- Wrap: owner 3 completes a burst -> `rr_ptr`=0; with reqs 0 and 3 both valid, req 0 wins next.
- Reset mid-burst: assert `rst` while LOCKED, `beat_cnt`=2, owner 2 -> `busy`=0 immediately; no `fifo_wr_en` while `rst` is high and all valids are held low. After release, with reqs 1 and 2 valid, req 1 wins (`rr_ptr`=0).
